// File: rtl/float_mul_sched.sv
// rtl/float_mul_sched.sv - round-robin scheduler sharing one pipelined FP multiplier among N_REQ requesters
// Optional occupancy output enabled by FLOAT_MUL_SCHED_OCC_EN.
module float_mul_sched #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_valid,
    input  logic [WIDTH-1:0]         mul_p,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic                     hold,
`ifdef FLOAT_MUL_SCHED_OCC_EN
    output logic [$clog2(LAT+2)-1:0] occ,
`endif
    output logic                     halted
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    state_t state, state_nxt;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic [IDW-1:0] mul_id;
    logic [LAT-1:0] tag_v;
    logic [IDW-1:0] tag_id [LAT];
    logic           pipe_empty;

    assign pipe_empty = !mul_valid && (tag_v == '0);

    // Scan from the round-robin pointer and take the first valid requester.
    always_comb begin
        int idx;
        req_ready = '0;
        gnt_id    = '0;
        gnt_any   = 1'b0;
        idx       = 0;
        if (nrst && state == RUN) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (!gnt_any && req_valid[IDW'(idx)]) begin
                    gnt_any              = 1'b1;
                    gnt_id               = IDW'(idx);
                    req_ready[IDW'(idx)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rr_ptr    <= '0;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_id    <= '0;
        end else begin
            mul_valid <= gnt_any;
            if (gnt_any) begin
                mul_a  <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
                mul_b  <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
                mul_id <= gnt_id;
                rr_ptr <= (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    // Tag pipe output lines up with mul_p, so the product can be routed directly.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            tag_v <= '0;
            for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            tag_v[0]  <= mul_valid;
            tag_id[0] <= mul_id;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (tag_v[LAT-1]) begin
                rsp_valid <= N_REQ'(1) << tag_id[LAT-1];
                rsp_data  <= mul_p;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == HALT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (hold) state_nxt = DRAIN;
            DRAIN:   if (!hold) state_nxt = RUN;
                     else if (pipe_empty) state_nxt = HALT;
            HALT:    if (!hold) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

`ifdef FLOAT_MUL_SCHED_OCC_EN
    localparam int OCCW = $clog2(LAT+2);

    always_ff @(posedge clk) begin
        if (!nrst) occ <= '0;
        else       occ <= OCCW'(int'(mul_valid) + $countones(tag_v));
    end

    always_ff @(posedge clk) begin
        if (nrst) assert (int'(occ) <= LAT+1);
    end
`endif
endmodule

// File: tb/tb_float_mul_sched.sv
// tb/tb_float_mul_sched.sv - directed self-checking bench for float_mul_sched with a table-driven multiplier stub
module tb_float_mul_sched;
    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int LAT   = 2;

    logic                     clk = 1'b0;
    logic                     nrst;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*WIDTH-1:0]   req_a;
    logic [N_REQ*WIDTH-1:0]   req_b;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_valid;
    logic [WIDTH-1:0]         mul_p;
    logic [N_REQ-1:0]         rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     hold;
    logic                     halted;
`ifdef FLOAT_MUL_SCHED_OCC_EN
    logic [$clog2(LAT+2)-1:0] occ;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Requester i multiplies (i+1).0 by 2.0.
    logic [31:0] opa  [N_REQ] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] prod [N_REQ] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    logic [WIDTH-1:0] mp [LAT];

    always #5 clk = ~clk;

    float_mul_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LAT(LAT)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_valid (mul_valid),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .hold      (hold),
`ifdef FLOAT_MUL_SCHED_OCC_EN
        .occ       (occ),
`endif
        .halted    (halted)
    );

    function automatic logic [31:0] fmul_tab(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40400000, 32'h40000000}: return 32'h40C00000;
            {32'h40800000, 32'h40000000}: return 32'h41000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        mp[0] <= fmul_tab(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_p = mp[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [N_REQ-1:0] er;
        logic [N_REQ-1:0] ev;
        logic             eh;
        nrst      = 1'b0;
        req_valid = '1;
        hold      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = opa[i];
            req_b[i*WIDTH +: WIDTH] = 32'h40000000;
        end

        // T1 reset
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_ready", req_ready, 0);
        end
        check("rst_mul_valid", mul_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_mul_a", mul_a, 0);

        // T2 single requester 2: 3.0 * 2.0
        @(negedge clk); nrst = 1'b1; req_valid = 4'b0100; #1;
        check("t2_ready", req_ready, 4'b0100);
        @(negedge clk); req_valid = '0; #1;
        check("t2_mul_valid", mul_valid, 1);
        check("t2_mul_a", mul_a, 32'h40400000);
        check("t2_mul_b", mul_b, 32'h40000000);
        repeat (2) begin
            @(negedge clk); #1;
            check("t2_rsp_early", rsp_valid, 0);
        end
        @(negedge clk); #1;
        check("t2_rsp_valid", rsp_valid, 4'b0100);
        check("t2_rsp_data", rsp_data, 32'h40C00000);
        @(negedge clk); #1;
        check("t2_rsp_once", rsp_valid, 0);

        // T5 reset mid-flight; pointer is 3 here, so the first grant wraps to 0
        @(negedge clk); req_valid = 4'b0011; #1;
        check("t5_wrap", req_ready, 4'b0001);
        @(negedge clk); #1;
        check("t5_next", req_ready, 4'b0010);
        @(negedge clk); req_valid = '0; nrst = 1'b0; #1;
        check("t5_rst_ready", req_ready, 0);
        repeat (4) begin
            @(negedge clk); nrst = 1'b1; #1;
            check("t5_dropped", rsp_valid, 0);
        end

        // T3 fairness from a reset pointer
        for (int j = 0; j < 13; j++) begin
            @(negedge clk); req_valid = (j < 8) ? '1 : '0; #1;
            er = (j < 8) ? N_REQ'(1) << (j % 4) : '0;
            check("t3_grant", req_ready, er);
            if (j >= 4 && j < 12) begin
                check("t3_rsp_valid", rsp_valid, N_REQ'(1) << ((j - 4) % 4));
                check("t3_rsp_data", rsp_data, prod[(j - 4) % 4]);
            end else begin
                check("t3_rsp_none", rsp_valid, 0);
            end
`ifdef FLOAT_MUL_SCHED_OCC_EN
            check("t6_occ", occ, int'(j-1 >= 1 && j-1 <= 8) + int'(j-1 >= 2 && j-1 <= 9)
                                 + int'(j-1 >= 3 && j-1 <= 10));
`endif
        end

        // T4 drain: hold raised in the cycle of the third grant
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            req_valid = (j <= 10) ? '1 : '0;
            hold      = (j >= 2 && j < 9);
            #1;
            er = (j < 3) ? N_REQ'(1) << j : (j == 10) ? 4'b1000 : 4'b0000;
            ev = (j >= 4 && j <= 6) ? N_REQ'(1) << (j - 4) : (j == 14) ? 4'b1000 : 4'b0000;
            eh = (j >= 7 && j <= 9);
            check("t4_ready", req_ready, er);
            check("t4_rsp_valid", rsp_valid, ev);
            check("t4_halted", halted, eh);
            if (j >= 4 && j <= 6) check("t4_rsp_data", rsp_data, prod[j - 4]);
            if (j == 14) check("t4_resume_data", rsp_data, prod[3]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
